// File: rtl/touch_coord_filter.sv
// touch_coord_filter: power-of-two window averaging of touch X/Y samples with frame-based pen-release debounce.
// Define TOUCH_SAMPLE_COUNT_EN to enable the saturating completed-window counter on Sample_Count.
module touch_coord_filter #(
    parameter int COORD_W        = 12,
    parameter int AVG_LOG2       = 2,
    parameter int RELEASE_CNT    = 4,
    parameter int GRID_COLS_LOG2 = 2,
    parameter int GRID_ROWS_LOG2 = 2
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      Touch_En,
    input  logic                      Coord_En,
    input  logic [COORD_W-1:0]        X_Coord,
    input  logic [COORD_W-1:0]        Y_Coord,
    input  logic                      Frame_Tick,
    output logic                      Touched,
    output logic                      Valid,
    output logic                      Release,
    output logic [COORD_W-1:0]        X_Avg,
    output logic [COORD_W-1:0]        Y_Avg,
    output logic [GRID_COLS_LOG2-1:0] Cell_Col,
    output logic [GRID_ROWS_LOG2-1:0] Cell_Row,
    output logic [15:0]               Sample_Count
);

    localparam int ACC_W = COORD_W + AVG_LOG2;
    localparam int WIN   = 1 << AVG_LOG2;
    localparam logic [AVG_LOG2:0] SCNT_LAST = (AVG_LOG2 + 1)'(WIN - 1);
    localparam logic [7:0]        RCNT_LAST = 8'(RELEASE_CNT - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               state;
    logic [ACC_W-1:0]     acc_x, acc_y;
    logic [ACC_W-1:0]     sum_x, sum_y;
    logic [COORD_W-1:0]   avg_x, avg_y;
    logic [AVG_LOG2:0]    scnt;
    logic [7:0]           rcnt;
    logic                 accept;
    logic                 win_done;

    // Truncating divide by the window size; no rounding.
    function automatic logic [COORD_W-1:0] trunc_avg(input logic [ACC_W-1:0] s);
        return COORD_W'(s >> AVG_LOG2);
    endfunction

    always_comb begin
        accept   = Coord_En & Touch_En;
        sum_x    = acc_x + ACC_W'(X_Coord);
        sum_y    = acc_y + ACC_W'(Y_Coord);
        avg_x    = trunc_avg(sum_x);
        avg_y    = trunc_avg(sum_y);
        win_done = accept && (scnt == SCNT_LAST);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            acc_x    <= '0;
            acc_y    <= '0;
            scnt     <= '0;
            rcnt     <= '0;
            Touched  <= 1'b0;
            Valid    <= 1'b0;
            Release  <= 1'b0;
            X_Avg    <= '0;
            Y_Avg    <= '0;
            Cell_Col <= '0;
            Cell_Row <= '0;
        end else begin
            Valid   <= 1'b0;
            Release <= 1'b0;
            if (accept) begin
                rcnt <= '0;
                if (win_done) begin
                    X_Avg    <= avg_x;
                    Y_Avg    <= avg_y;
                    Cell_Col <= avg_x[COORD_W-1 -: GRID_COLS_LOG2];
                    Cell_Row <= avg_y[COORD_W-1 -: GRID_ROWS_LOG2];
                    Valid    <= 1'b1;
                    Touched  <= 1'b1;
                    acc_x    <= '0;
                    acc_y    <= '0;
                    scnt     <= '0;
                    state    <= HOLD;
                end else begin
                    acc_x <= sum_x;
                    acc_y <= sum_y;
                    scnt  <= scnt + 1'b1;
                    if (state == IDLE)
                        state <= ACCUM;
                end
            end else if (state != IDLE) begin
                // Pen-up debounce: only consecutive untouched frames count.
                if (Touch_En) begin
                    rcnt <= '0;
                end else if (Frame_Tick) begin
                    if (rcnt == RCNT_LAST) begin
                        state <= IDLE;
                        acc_x <= '0;
                        acc_y <= '0;
                        scnt  <= '0;
                        rcnt  <= '0;
                        if (state == HOLD) begin
                            Touched <= 1'b0;
                            Release <= 1'b1;
                        end
                    end else begin
                        rcnt <= rcnt + 8'd1;
                    end
                end
            end
        end
    end

`ifdef TOUCH_SAMPLE_COUNT_EN
    logic [15:0] sample_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            sample_cnt <= '0;
        else if (win_done)
            sample_cnt <= sat_inc(sample_cnt);
    end

    assign Sample_Count = sample_cnt;
`else
    assign Sample_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_touch_coord_filter.sv
// Testbench for touch_coord_filter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_touch_coord_filter;

    localparam int COORD_W   = 12;
    localparam int WIN       = 4;
    localparam int REL_CNT   = 4;
    localparam int COL_SPAN  = 4096 / 4;
    localparam int ROW_SPAN  = 4096 / 4;
`ifdef TOUCH_SAMPLE_COUNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic               Clock = 1'b0;
    logic               Resetn;
    logic               Touch_En, Coord_En, Frame_Tick;
    logic [COORD_W-1:0] X_Coord, Y_Coord;
    logic               Touched, Valid, Release;
    logic [COORD_W-1:0] X_Avg, Y_Avg;
    logic [1:0]         Cell_Col, Cell_Row;
    logic [15:0]        Sample_Count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int q_x[$];
    int q_y[$];
    bit m_touched, m_valid, m_rel;
    int m_frames, m_x, m_y, m_cnt;

    always #5 Clock = ~Clock;

    touch_coord_filter dut (
        .Clock(Clock), .Resetn(Resetn), .Touch_En(Touch_En), .Coord_En(Coord_En),
        .X_Coord(X_Coord), .Y_Coord(Y_Coord), .Frame_Tick(Frame_Tick),
        .Touched(Touched), .Valid(Valid), .Release(Release),
        .X_Avg(X_Avg), .Y_Avg(Y_Avg), .Cell_Col(Cell_Col), .Cell_Row(Cell_Row),
        .Sample_Count(Sample_Count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_x.delete(); q_y.delete();
        m_touched = 0; m_valid = 0; m_rel = 0;
        m_frames = 0; m_x = 0; m_y = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit te, input bit ce, input int x, input int y, input bit ft);
        int sx, sy;
        bit active;
        active  = m_touched || (q_x.size() != 0);
        m_valid = 0;
        m_rel   = 0;
        if (te && ce) begin
            q_x.push_back(x);
            q_y.push_back(y);
            m_frames = 0;
            if (q_x.size() == WIN) begin
                sx = 0; sy = 0;
                foreach (q_x[i]) begin sx += q_x[i]; sy += q_y[i]; end
                m_x = sx / WIN;
                m_y = sy / WIN;
                m_valid = 1;
                m_touched = 1;
                q_x.delete(); q_y.delete();
                if (CNT_EN != 0 && m_cnt < 65535) m_cnt++;
            end
        end else if (active) begin
            if (te) m_frames = 0;
            else if (ft) begin
                m_frames++;
                if (m_frames == REL_CNT) begin
                    if (m_touched) m_rel = 1;
                    m_touched = 0;
                    m_frames = 0;
                    q_x.delete(); q_y.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("touched", Touched, m_touched);
        check_eq("valid", Valid, m_valid);
        check_eq("release", Release, m_rel);
        check_eq("x_avg", X_Avg, m_x);
        check_eq("y_avg", Y_Avg, m_y);
        check_eq("cell_col", Cell_Col, m_x / COL_SPAN);
        check_eq("cell_row", Cell_Row, m_y / ROW_SPAN);
        check_eq("sample_count", Sample_Count, m_cnt);
    endtask

    task automatic cycle(input bit te, input bit ce, input int x, input int y, input bit ft);
        @(negedge Clock);
        Touch_En = te; Coord_En = ce; Frame_Tick = ft;
        X_Coord = COORD_W'(x); Y_Coord = COORD_W'(y);
        @(posedge Clock);
        model_step(te, ce, x, y, ft);
        #1 check_outputs();
    endtask

    task automatic sample(input int x, input int y);
        cycle(1, 1, x, y, 0);
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic ticks_untouched(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_touched"}, Touched, 0);
        check_eq({tag, "_valid"}, Valid, 0);
        check_eq({tag, "_release"}, Release, 0);
        check_eq({tag, "_x"}, X_Avg, 0);
        check_eq({tag, "_y"}, Y_Avg, 0);
        check_eq({tag, "_cells"}, {Cell_Col, Cell_Row}, 0);
        check_eq({tag, "_scnt"}, Sample_Count, 0);
    endtask

    initial begin
        Resetn = 1'b0;
        Touch_En = 0; Coord_En = 0; Frame_Tick = 0; X_Coord = '0; Y_Coord = '0;
        model_reset();
        #2 check_all_zero("reset");
        repeat (3) @(posedge Clock);
        @(negedge Clock) Resetn = 1'b1;

        // Strobes without pen-down are ignored
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 500, 500, 0);
            cycle(0, 0, 0, 0, 0);
        end
        check_eq("ignore_touched", Touched, 0);
        check_eq("ignore_x", X_Avg, 0);

        // Basic average, latency one cycle after 4th strobe
        sample(100, 200); sample(104, 200); sample(108, 200);
        cycle(1, 1, 112, 200, 0);
        check_eq("tp1_valid", Valid, 1);
        check_eq("tp1_x", X_Avg, 106);
        check_eq("tp1_y", Y_Avg, 200);
        check_eq("tp1_touched", Touched, 1);
        check_eq("tp1_cells", {Cell_Col, Cell_Row}, 0);
        cycle(1, 0, 0, 0, 0);

        // Full-scale window, then a second window in HOLD
        for (int i = 0; i < 4; i++) sample(4095, 100);
        check_eq("tp2_x_max", X_Avg, 4095);
        check_eq("tp2_col_max", Cell_Col, 3);
        for (int i = 0; i < 4; i++) sample(1024, 100);
        check_eq("tp2_x", X_Avg, 1024);
        check_eq("tp2_col", Cell_Col, 1);
        check_eq("tp6_scnt", Sample_Count, 3 * CNT_EN);

        // Interrupted debounce, then real release
        ticks_untouched(3);
        check_eq("tp3_still_touched", Touched, 1);
        cycle(1, 0, 0, 0, 0);
        ticks_untouched(3);
        check_eq("tp3_pre_touched", Touched, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("tp3_release", Release, 1);
        check_eq("tp3_touched", Touched, 0);
        check_eq("tp3_x_held", X_Avg, 1024);
        cycle(0, 0, 0, 0, 0);
        check_eq("tp3_release_pulse", Release, 0);

        // Partial window discarded on release from ACCUM
        sample(4000, 4000); sample(4000, 4000);
        ticks_untouched(4);
        check_eq("tp4_no_release", Release, 0);
        check_eq("tp4_x_held", X_Avg, 1024);
        for (int i = 0; i < 4; i++) sample(8, 8);
        check_eq("tp4_x", X_Avg, 8);
        check_eq("tp4_y", Y_Avg, 8);

        // Asynchronous reset mid-window
        sample(50, 60); sample(70, 80);
        @(negedge Clock);
        Coord_En = 0;
        #2 Resetn = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        repeat (2) @(posedge Clock);
        @(negedge Clock) Resetn = 1'b1;
        for (int i = 0; i < 4; i++) sample(20, 40);
        check_eq("postreset_x", X_Avg, 20);

        // Randomized traffic in touch/release bursts
        for (int b = 0; b < 100; b++) begin
            bit burst_touch;
            burst_touch = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < 30; c++) begin
                bit te, ce, ft;
                te = burst_touch ? ($urandom_range(0, 15) != 0) : 1'b0;
                ce = ($urandom_range(0, 2) == 0);
                ft = ($urandom_range(0, 3) == 0);
                cycle(te, ce, $urandom_range(0, 4095), $urandom_range(0, 4095), ft);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
